step_sequencer_ctrl: RTL and testbench

Tempo controller that sequences the 4-bit deck step counter. It divides the system clock into step ticks of programmable length and advances the step index through a programmable loop. Start, stop and pause commands come from the deck transport logic. It also emits step and bar strobes, which the sample-trigger and display logic downstream consume.

---
 rtl/seq_pkg.sv | 15 +
 rtl/tick_divider.sv | 60 ++++++
 rtl/step_sequencer_ctrl.sv | 116 +++++++++++
 tb/tb_step_sequencer_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the deck step sequencer.
package seq_pkg;

    // Transport state of the sequencer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } seq_state_t;

    // Default divider width (cycles per step) and step index width (16 steps)
    localparam int SEQ_DIV_W  = 24;
    localparam int SEQ_STEP_W = 4;

endpackage

// File: rtl/tick_divider.sv
// Step-length divider: counts 0..P-1 and flags the terminal count on the
// edge where the count wraps. The period is latched on clear and at every
// wrap, so a new period only takes effect at a step boundary.
module tick_divider
    import seq_pkg::*;
#(
    parameter int DIV_W = SEQ_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    input  logic [DIV_W-1:0] period,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic             at_end;

    // A period of zero would never terminate, so it behaves as one cycle
    function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] p);
        return (p == '0) ? DIV_W'(1) : p;
    endfunction

    // per_q is never zero, so per_q-1 cannot underflow
    assign at_end = (cnt_q == (per_q - DIV_W'(1)));

    // Terminal count only counts when the divider actually advances this edge
    assign tc = at_end & ~hold & ~clear;

    // Next count and period: clear restarts, hold freezes, else count and wrap
    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (clear) begin
            cnt_d = '0;
            per_d = eff_period(period);
        end else if (!hold) begin
            if (at_end) begin
                cnt_d = '0;
                per_d = eff_period(period);
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Divider registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            per_q <= DIV_W'(1);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Tempo controller for the deck step counter: transport FSM, step register
// and the step/bar strobes. Step timing comes from tick_divider.
module step_sequencer_ctrl
    import seq_pkg::*;
#(
    parameter int DIV_W  = SEQ_DIV_W,
    parameter int STEP_W = SEQ_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [DIV_W-1:0]  tick_period,
    input  logic [STEP_W-1:0] loop_last,
    output logic [STEP_W-1:0] step,
    output logic              step_en,
    output logic              bar_start,
    output logic              running
);

    seq_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              step_en_q, step_en_d;
    logic              bar_start_q, bar_start_d;
    logic              running_q, running_d;

    logic div_clear;
    logic div_hold;
    logic tc;

    // Both stop and start rewind the divider to zero
    assign div_clear = stop | start;

    // The divider advances in RUN unless pausing on this edge, and on the edge
    // that resumes from PAUSED; this makes the paused time add exactly to the step
    assign div_hold = ~(((state_q == RUN) && !pause) || ((state_q == PAUSED) && pause));

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .hold   (div_hold),
        .period (tick_period),
        .tc     (tc)
    );

    // Next state, step and strobes; command priority is stop > start > pause
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        step_en_d   = 1'b0;
        bar_start_d = 1'b0;
        if (stop) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (start) begin
            state_d     = RUN;
            step_d      = '0;
            step_en_d   = 1'b1;
            bar_start_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // tc is already qualified by hold/clear, so it marks a real boundary
            if (tc) begin
                step_en_d = 1'b1;
                if (step_q >= loop_last) begin
                    step_d      = '0;
                    bar_start_d = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
        end
        running_d = (state_d == RUN);
    end

    // Registered FSM state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            step_en_q   <= 1'b0;
            bar_start_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            step_en_q   <= step_en_d;
            bar_start_q <= bar_start_d;
            running_q   <= running_d;
        end
    end

    assign step      = step_q;
    assign step_en   = step_en_q;
    assign bar_start = bar_start_q;
    assign running   = running_q;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Directed bench for step_sequencer_ctrl with an expectation queue.
module tb_step_sequencer_ctrl;

    localparam int DIV_W  = 24;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              pause;
    logic [DIV_W-1:0]  tick_period;
    logic [STEP_W-1:0] loop_last;
    logic [STEP_W-1:0] step;
    logic              step_en;
    logic              bar_start;
    logic              running;

    always #5 clk = ~clk;

    step_sequencer_ctrl #(
        .DIV_W  (DIV_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .tick_period (tick_period),
        .loop_last   (loop_last),
        .step        (step),
        .step_en     (step_en),
        .bar_start   (bar_start),
        .running     (running)
    );

    // {step, step_en, bar_start, running}
    typedef logic [6:0] obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic obs_t pack(input int st, input bit en, input bit bar, input bit run);
        logic [3:0] s;
        s = 4'(st);
        return {s, en, bar, run};
    endfunction

    task automatic expect_next(input string tag, input int st, input bit en, input bit bar, input bit run);
        exp_q.push_back(pack(st, en, bar, run));
        tag_q.push_back(tag);
    endtask

    // Advance one clock, drop the pulse inputs, and score the oldest expectation
    task automatic tick();
        obs_t  e;
        obs_t  o;
        string t;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = {step, step_en, bar_start, running};
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s actual{step,en,bar,run}=%h required=%h", t, o, e);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        tick_period = 24'd4;
        loop_last   = 4'd3;

        // Reset state
        expect_next("reset0", 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        expect_next("reset1", 0, 0, 0, 0);
        tick();
        // Pause in IDLE is ignored
        pause = 1'b1;
        expect_next("idle_pause", 0, 0, 0, 0);
        tick();

        // P=4, loop 0..3: strobes at 1,5,9,13,17; bars at 1 and 17
        start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            expect_next("run_p4", ((k - 1) / 4) % 4, ((k - 1) % 4) == 0, ((k - 1) % 16) == 0, 1'b1);
            tick();
        end

        // Pause three cycles after the step at cycle 17, stay paused 10 cycles
        for (int k = 18; k <= 20; k++) begin
            expect_next("pre_pause", 0, 0, 0, 1);
            tick();
        end
        pause = 1'b1;
        for (int k = 21; k <= 30; k++) begin
            expect_next("paused", 0, 0, 0, 0);
            tick();
        end
        pause = 1'b1;
        expect_next("resume_step", 1, 1, 0, 1);
        tick();
        for (int k = 32; k <= 35; k++) begin
            expect_next("post_resume", (k == 35) ? 2 : 1, k == 35, 0, 1);
            tick();
        end

        // Restart at step 2; period change mid-step waits for the boundary
        start = 1'b1;
        expect_next("restart", 0, 1, 1, 1);
        tick();
        tick_period = 24'd2;
        for (int k = 37; k <= 46; k++) begin
            int j;
            int m;
            int st;
            bit en;
            j = k - 36;
            if (j < 4) begin
                expect_next("restart_hold", 0, 0, 0, 1);
            end else begin
                m  = j - 4;
                st = (1 + m / 2) % 4;
                en = (m % 2) == 0;
                expect_next("new_period", st, en, en && (st == 0), 1);
            end
            tick();
        end

        // Loop shortened from 7 to 2 while step=5
        loop_last = 4'd7;
        start     = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            expect_next("loop7", j / 2, (j % 2) == 0, j == 0, 1);
            tick();
            if (j == 10) loop_last = 4'd2;
        end
        expect_next("loop_shrink", 0, 1, 1, 1);
        tick();
        expect_next("loop_shrink_hold", 0, 0, 0, 1);
        tick();
        expect_next("loop_shrink_next", 1, 1, 0, 1);
        tick();

        // tick_period=0 behaves as 1: strobe and advance every cycle
        tick_period = 24'd0;
        loop_last   = 4'd15;
        start       = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            expect_next("p0", j % 16, 1, (j % 16) == 0, 1);
            tick();
        end

        // Stop together with pause: stop wins
        stop  = 1'b1;
        pause = 1'b1;
        expect_next("stop_pause", 0, 0, 0, 0);
        tick();
        pause = 1'b1;
        expect_next("idle_after_stop", 0, 0, 0, 0);
        tick();

        // Reset on the terminal-count cycle: no strobe
        tick_period = 24'd3;
        loop_last   = 4'd3;
        start       = 1'b1;
        expect_next("tc_rst_start", 0, 1, 1, 1);
        tick();
        expect_next("tc_rst_c2", 0, 0, 0, 1);
        tick();
        expect_next("tc_rst_c3", 0, 0, 0, 1);
        tick();
        reset = 1'b1;
        expect_next("reset_on_tc", 0, 0, 0, 0);
        tick();
        expect_next("reset_on_tc_idle", 0, 0, 0, 0);
        tick();

        // Stop on the terminal-count cycle: no strobe
        start = 1'b1;
        expect_next("tc_stop_start", 0, 1, 1, 1);
        tick();
        expect_next("tc_stop_c2", 0, 0, 0, 1);
        tick();
        expect_next("tc_stop_c3", 0, 0, 0, 1);
        tick();
        stop = 1'b1;
        expect_next("stop_on_tc", 0, 0, 0, 0);
        tick();
        expect_next("stop_on_tc_idle", 0, 0, 0, 0);
        tick();

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
